// File: rtl/kp_pkg.sv
// Shared types and key-position helpers for the keypad emulator.
// Key codes are row-major: code = row*3 + col.
package kp_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 3;
    localparam int KP_KEYS = 12;

    typedef logic [3:0] key_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [1:0] key_row(input key_t k);
        key_row = 2'(k / 4'd3);
    endfunction

    function automatic logic [1:0] key_col(input key_t k);
        key_col = 2'(k % 4'd3);
    endfunction

    function automatic logic key_is_valid(input key_t k);
        key_is_valid = (k < 4'(KP_KEYS));
    endfunction

endpackage

// File: rtl/kp_fifo.sv
// Key-code queue: DEPTH x 4-bit synchronous FIFO with registered full/empty.
// A push while full is taken only if a pop happens in the same cycle.
module kp_fifo
    import kp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  key_t din,
    output key_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    key_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            do_push, do_pop;

    always_comb begin
        do_pop   = pop & ~empty_q;
        do_push  = push & (~full_q | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/keypad_emulator.sv
// Presses queued key codes on a 4x3 keypad matrix by returning the scanner's
// row drive on the key's column; holds for HOLD_SCANS scans, releases for GAP_SCANS.
//
// state | meaning
// IDLE  | waiting for a queued key
// PRESS | key held: COL[c] follows ROW[r]
// GAP   | key released, counting scans before the next key
module keypad_emulator
    import kp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HOLD_SCANS = 3,
    parameter int GAP_SCANS  = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ROW,
    output logic [2:0] COL,
    input  logic [3:0] KEY,
    input  logic       KEY_VALID,
    output logic       KEY_READY,
    output logic       BUSY,
    output logic       ERR,
    output logic [7:0] DEBUG
);

    localparam int SCAN_MAX = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
    localparam int SCAN_W   = $clog2(SCAN_MAX + 1);
    localparam int TO_W     = $clog2(TIMEOUT);

    localparam logic [SCAN_W-1:0] HOLD_N  = SCAN_W'(HOLD_SCANS);
    localparam logic [SCAN_W-1:0] GAP_N   = SCAN_W'(GAP_SCANS);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    key_t                cur_key_q, cur_key_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d, scan_inc;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d, to_inc;
    logic [3:0]          row_q;
    logic                err_q, err_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    key_t                fifo_dout;
    logic                key_accept;
    logic [1:0]          row_r, col_c;
    logic                row_hit, row_edge, phase_done, timeout_hit;

    assign key_accept = KEY_VALID & ~fifo_full;
    assign fifo_push  = key_accept & key_is_valid(KEY);

    kp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (KEY),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign row_r    = key_row(cur_key_q);
    assign col_c    = key_col(cur_key_q);
    assign row_hit  = ROW[row_r];
    assign row_edge = ROW[row_r] & ~row_q[row_r];
    assign scan_inc = (scan_cnt_q == {SCAN_W{1'b1}}) ? scan_cnt_q : scan_cnt_q + SCAN_W'(1);
    assign to_inc   = (to_cnt_q == {TO_W{1'b1}}) ? to_cnt_q : to_cnt_q + TO_W'(1);

    always_comb begin
        state_d     = state_q;
        cur_key_d   = cur_key_q;
        scan_cnt_d  = scan_cnt_q;
        to_cnt_d    = to_cnt_q;
        fifo_pop    = 1'b0;
        timeout_hit = 1'b0;
        COL         = 3'b000;
        // A phase ends once its scans are counted and the key's row has dropped,
        // so the last counted row activation is never cut short.
        phase_done  = ~row_hit &
                      (((state_q == PRESS) && (scan_cnt_q == HOLD_N)) ||
                       ((state_q == GAP)   && (scan_cnt_q == GAP_N)));

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_key_d  = fifo_dout;
                    scan_cnt_d = '0;
                    to_cnt_d   = '0;
                    state_d    = PRESS;
                end
            end
            PRESS, GAP: begin
                if (state_q == PRESS && row_hit) COL = 3'b001 << col_c;
                if (phase_done) begin
                    state_d    = (state_q == PRESS) ? GAP : IDLE;
                    scan_cnt_d = '0;
                    to_cnt_d   = to_inc;
                end else if (row_edge) begin
                    scan_cnt_d = scan_inc;
                    to_cnt_d   = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = (key_accept & ~key_is_valid(KEY)) | timeout_hit;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cur_key_q  <= '0;
            scan_cnt_q <= '0;
            to_cnt_q   <= '0;
            row_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_key_q  <= cur_key_d;
            scan_cnt_q <= scan_cnt_d;
            to_cnt_q   <= to_cnt_d;
            row_q      <= ROW;
            err_q      <= err_d;
        end
    end

    assign KEY_READY = ~fifo_full;
    assign BUSY      = ~fifo_empty | (state_q != IDLE);
    assign ERR       = err_q;
    assign DEBUG     = {state_q, 2'b00, cur_key_q};

endmodule
